// File: rtl/p4_router_pkt_queue.sv
// p4_router_pkt_queue: store-and-forward AXI-Stream packet buffer.
// Whole packets are committed on their tlast beat; packets that would overflow
// the buffer, exceed the packet limit or exceed the MTU are dropped in full.
module p4_router_pkt_queue #(
  parameter int DATA_BYTES  = 8,
  parameter int TUSER_WIDTH = 8,
  parameter int DEPTH_WORDS = 2048,
  parameter int MAX_PKTS    = 64,
  parameter int MTU_BYTES   = 9600
) (
  input  logic                          clk,
  input  logic                          sresetn,
  input  logic                          in_tvalid,
  output logic                          in_tready,
  input  logic [DATA_BYTES*8-1:0]       in_tdata,
  input  logic [DATA_BYTES-1:0]         in_tkeep,
  input  logic                          in_tlast,
  input  logic [TUSER_WIDTH-1:0]        in_tuser,
  output logic                          out_tvalid,
  input  logic                          out_tready,
  output logic [DATA_BYTES*8-1:0]       out_tdata,
  output logic [DATA_BYTES-1:0]         out_tkeep,
  output logic                          out_tlast,
  output logic [TUSER_WIDTH-1:0]        out_tuser,
  input  logic                          stat_clear,
  output logic [$clog2(DEPTH_WORDS):0]  fill_words,
  output logic [$clog2(MAX_PKTS+1)-1:0] pkt_count,
  output logic                          drop_pulse,
  output logic [31:0]                   drop_full_cnt,
  output logic [31:0]                   drop_mtu_cnt
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(MAX_PKTS + 1);
  localparam int DW = DATA_BYTES * 8;
  localparam int WW = 1 + TUSER_WIDTH + DATA_BYTES + DW;
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH_PTR = PW'(DEPTH_WORDS);
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_PKTS);

  if ((DEPTH_WORDS < 4) || ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0)) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of 2 and at least 4");
  end
  if (MTU_BYTES > DEPTH_WORDS * DATA_BYTES) begin : g_bad_mtu
    $error("MTU_BYTES must not exceed DEPTH_WORDS*DATA_BYTES");
  end
  if (!(DATA_BYTES inside {1, 2, 4, 8, 16, 32, 64})) begin : g_bad_width
    $error("DATA_BYTES must be 1, 2, 4, 8, 16, 32 or 64");
  end

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PKT = 2'd1, ST_DISCARD = 2'd2} wr_state_e;

  function automatic logic [31:0] popcount(input logic [DATA_BYTES-1:0] v);
    logic [31:0] n;
    n = 32'd0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

  // Saturating statistics counter; a clear wins over a coincident increment.
  function automatic logic [31:0] sat_next(input logic [31:0] cnt, input logic inc, input logic clr);
    logic [31:0] r;
    if (clr) begin
      r = 32'd0;
    end else if (inc && (cnt != 32'hFFFF_FFFF)) begin
      r = cnt + 32'd1;
    end else begin
      r = cnt;
    end
    return r;
  endfunction

  logic [WW-1:0]          mem_q [DEPTH_WORDS];
  logic [WW-1:0]          rdata_q, out_word_q, out_word_d, wr_word_s;
  wr_state_e              state_q, state_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]          fetch_ptr_q, fetch_ptr_d, rd_ptr_q, rd_ptr_d, fill_q, occ_s;
  logic [CW-1:0]          pkt_count_q, pkt_count_d;
  logic [31:0]            byte_cnt_q, byte_cnt_d, beat_bytes_s, byte_sum_s;
  logic [31:0]            drop_full_q, drop_mtu_q;
  logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;
  logic                   drop_full_r_q, drop_full_r_d;
  logic                   in_tready_q, rv_q, rv_d, out_tvalid_q, out_tvalid_d, drop_pulse_q;
  logic                   accept_s, ovf_s, mtu_s, wr_en_s, commit_s, full_inc_s, mtu_inc_s;
  logic                   rd_en_s, load_out_s, out_hs_s, out_pop_s;

  assign accept_s     = in_tvalid && in_tready_q;
  assign occ_s        = wr_ptr_q - rd_ptr_q;
  assign ovf_s        = (occ_s == DEPTH_PTR) || ((state_q == ST_IDLE) && (pkt_count_q == MAX_CNT));
  assign beat_bytes_s = in_tlast ? popcount(in_tkeep) : 32'(DATA_BYTES);
  assign byte_sum_s   = ((state_q == ST_IDLE) ? 32'd0 : byte_cnt_q) + beat_bytes_s;
  assign mtu_s        = byte_sum_s > 32'(MTU_BYTES);
  assign wr_word_s    = {in_tlast, ((state_q == ST_IDLE) ? in_tuser : tuser_q), in_tkeep, in_tdata};

  // Write FSM: speculative writes, commit on a good tlast, rewind on a drop.
  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    commit_ptr_d  = commit_ptr_q;
    byte_cnt_d    = byte_cnt_q;
    drop_full_r_d = drop_full_r_q;
    wr_en_s       = 1'b0;
    commit_s      = 1'b0;
    full_inc_s    = 1'b0;
    mtu_inc_s     = 1'b0;
    if (accept_s && (state_q == ST_IDLE)) begin
      tuser_d = in_tuser;
    end else begin
      tuser_d = tuser_q;
    end
    if (accept_s) begin
      case (state_q)
        ST_IDLE, ST_PKT: begin
          if (ovf_s || mtu_s) begin
            wr_ptr_d = commit_ptr_q;
            if (in_tlast) begin
              full_inc_s = ovf_s;
              mtu_inc_s  = !ovf_s;
              state_d    = ST_IDLE;
            end else begin
              drop_full_r_d = ovf_s;
              state_d       = ST_DISCARD;
            end
          end else begin
            wr_en_s    = 1'b1;
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
            byte_cnt_d = byte_sum_s;
            if (in_tlast) begin
              commit_s     = 1'b1;
              commit_ptr_d = wr_ptr_q + PTR_ONE;
              state_d      = ST_IDLE;
            end else begin
              state_d = ST_PKT;
            end
          end
        end
        ST_DISCARD: begin
          if (in_tlast) begin
            full_inc_s = drop_full_r_q;
            mtu_inc_s  = !drop_full_r_q;
            state_d    = ST_IDLE;
          end else begin
            state_d = ST_DISCARD;
          end
        end
        default: begin
          wr_ptr_d = commit_ptr_q;
          state_d  = ST_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  assign load_out_s = !out_tvalid_q || out_tready;
  assign out_hs_s   = out_tvalid_q && out_tready;
  assign out_pop_s  = out_hs_s && out_word_q[WW-1];
  assign rd_en_s    = (commit_ptr_q != fetch_ptr_q) && (!rv_q || load_out_s);

  // Read side: prefetch register feeding the output register, plus occupancy.
  always_comb begin
    fetch_ptr_d  = rd_en_s ? (fetch_ptr_q + PTR_ONE) : fetch_ptr_q;
    rd_ptr_d     = out_hs_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    out_tvalid_d = out_tvalid_q;
    out_word_d   = out_word_q;
    if (rd_en_s) begin
      rv_d = 1'b1;
    end else if (load_out_s) begin
      rv_d = 1'b0;
    end else begin
      rv_d = rv_q;
    end
    if (load_out_s) begin
      out_tvalid_d = rv_q;
      out_word_d   = rv_q ? rdata_q : out_word_q;
    end else begin
      out_tvalid_d = out_tvalid_q;
    end
    case ({commit_s, out_pop_s})
      2'b10:   pkt_count_d = pkt_count_q + CNT_ONE;
      2'b01:   pkt_count_d = pkt_count_q - CNT_ONE;
      default: pkt_count_d = pkt_count_q;
    endcase
  end

  // Control, pointer, output and statistics registers.
  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q       <= ST_IDLE;
      in_tready_q   <= 1'b0;
      wr_ptr_q      <= '0;
      commit_ptr_q  <= '0;
      fetch_ptr_q   <= '0;
      rd_ptr_q      <= '0;
      fill_q        <= '0;
      pkt_count_q   <= '0;
      byte_cnt_q    <= 32'd0;
      tuser_q       <= '0;
      drop_full_r_q <= 1'b0;
      rv_q          <= 1'b0;
      out_tvalid_q  <= 1'b0;
      out_word_q    <= '0;
      drop_pulse_q  <= 1'b0;
      drop_full_q   <= 32'd0;
      drop_mtu_q    <= 32'd0;
    end else begin
      state_q       <= state_d;
      in_tready_q   <= 1'b1;
      wr_ptr_q      <= wr_ptr_d;
      commit_ptr_q  <= commit_ptr_d;
      fetch_ptr_q   <= fetch_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= commit_ptr_d - rd_ptr_d;
      pkt_count_q   <= pkt_count_d;
      byte_cnt_q    <= byte_cnt_d;
      tuser_q       <= tuser_d;
      drop_full_r_q <= drop_full_r_d;
      rv_q          <= rv_d;
      out_tvalid_q  <= out_tvalid_d;
      out_word_q    <= out_word_d;
      drop_pulse_q  <= full_inc_s || mtu_inc_s;
      drop_full_q   <= sat_next(drop_full_q, full_inc_s, stat_clear);
      drop_mtu_q    <= sat_next(drop_mtu_q, mtu_inc_s, stat_clear);
    end
  end

  // Buffer write port and registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_word_s;
    end
    if (rd_en_s) begin
      rdata_q <= mem_q[fetch_ptr_q[AW-1:0]];
    end
  end

  assign in_tready     = in_tready_q;
  assign out_tvalid    = out_tvalid_q;
  assign out_tdata     = out_word_q[DW-1:0];
  assign out_tkeep     = out_word_q[DW +: DATA_BYTES];
  assign out_tuser     = out_word_q[DW+DATA_BYTES +: TUSER_WIDTH];
  assign out_tlast     = out_word_q[WW-1];
  assign fill_words    = fill_q;
  assign pkt_count     = pkt_count_q;
  assign drop_pulse    = drop_pulse_q;
  assign drop_full_cnt = drop_full_q;
  assign drop_mtu_cnt  = drop_mtu_q;

endmodule

// File: tb/tb_p4_router_pkt_queue.sv
// Directed bench: a main queue (DEPTH 16, 4 packets, MTU 128) and a limited
// queue (DEPTH 16, 2 packets, MTU 64) share one input stream and out_tready.
module tb_p4_router_pkt_queue;

  typedef logic [80:0] beat_t;  // {tlast, tuser[7:0], tkeep[7:0], tdata[63:0]}

  logic        clk = 1'b0;
  logic        sresetn = 1'b0;
  logic        in_tvalid = 1'b0;
  logic [63:0] in_tdata = 64'd0;
  logic [7:0]  in_tkeep = 8'd0;
  logic        in_tlast = 1'b0;
  logic [7:0]  in_tuser = 8'd0;
  logic        out_tready = 1'b0;
  logic        stat_clear = 1'b0;

  logic        m_in_tready, m_out_tvalid, m_out_tlast, m_drop_pulse;
  logic [63:0] m_out_tdata;
  logic [7:0]  m_out_tkeep, m_out_tuser;
  logic [4:0]  m_fill_words;
  logic [2:0]  m_pkt_count;
  logic [31:0] m_drop_full_cnt, m_drop_mtu_cnt;

  logic        l_in_tready, l_out_tvalid, l_out_tlast, l_drop_pulse;
  logic [63:0] l_out_tdata;
  logic [7:0]  l_out_tkeep, l_out_tuser;
  logic [4:0]  l_fill_words;
  logic [1:0]  l_pkt_count;
  logic [31:0] l_drop_full_cnt, l_drop_mtu_cnt;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    m_pulses = 0;
  int    l_pulses = 0;
  beat_t mq[$];
  beat_t lq[$];
  int    mstamp[$];

  always #5 clk = ~clk;

  p4_router_pkt_queue #(
    .DATA_BYTES(8), .TUSER_WIDTH(8), .DEPTH_WORDS(16), .MAX_PKTS(4), .MTU_BYTES(128)
  ) u_main (
    .clk(clk), .sresetn(sresetn),
    .in_tvalid(in_tvalid), .in_tready(m_in_tready), .in_tdata(in_tdata),
    .in_tkeep(in_tkeep), .in_tlast(in_tlast), .in_tuser(in_tuser),
    .out_tvalid(m_out_tvalid), .out_tready(out_tready), .out_tdata(m_out_tdata),
    .out_tkeep(m_out_tkeep), .out_tlast(m_out_tlast), .out_tuser(m_out_tuser),
    .stat_clear(stat_clear), .fill_words(m_fill_words), .pkt_count(m_pkt_count),
    .drop_pulse(m_drop_pulse), .drop_full_cnt(m_drop_full_cnt), .drop_mtu_cnt(m_drop_mtu_cnt)
  );

  p4_router_pkt_queue #(
    .DATA_BYTES(8), .TUSER_WIDTH(8), .DEPTH_WORDS(16), .MAX_PKTS(2), .MTU_BYTES(64)
  ) u_lim (
    .clk(clk), .sresetn(sresetn),
    .in_tvalid(in_tvalid), .in_tready(l_in_tready), .in_tdata(in_tdata),
    .in_tkeep(in_tkeep), .in_tlast(in_tlast), .in_tuser(in_tuser),
    .out_tvalid(l_out_tvalid), .out_tready(out_tready), .out_tdata(l_out_tdata),
    .out_tkeep(l_out_tkeep), .out_tlast(l_out_tlast), .out_tuser(l_out_tuser),
    .stat_clear(stat_clear), .fill_words(l_fill_words), .pkt_count(l_pkt_count),
    .drop_pulse(l_drop_pulse), .drop_full_cnt(l_drop_full_cnt), .drop_mtu_cnt(l_drop_mtu_cnt)
  );

  // Free-running cycle stamp.
  always @(posedge clk) cyc <= cyc + 1;

  // Output and drop-pulse monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (m_out_tvalid && out_tready) begin
      mq.push_back({m_out_tlast, m_out_tuser, m_out_tkeep, m_out_tdata});
      mstamp.push_back(cyc);
    end
    if (l_out_tvalid && out_tready) lq.push_back({l_out_tlast, l_out_tuser, l_out_tkeep, l_out_tdata});
    if (m_drop_pulse) m_pulses <= m_pulses + 1;
    if (l_drop_pulse) l_pulses <= l_pulses + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input bit use_lim, input int start, input int n,
                         input logic [63:0] base, input logic [7:0] lastkeep, input logic [7:0] user);
    beat_t got, exp;
    for (int i = 0; i < n; i++) begin
      exp = {(i == n - 1), user, ((i == n - 1) ? lastkeep : 8'hFF), base + 64'(i)};
      got = '0;
      if (use_lim) begin
        if (start + i < lq.size()) got = lq[start + i];
      end else begin
        if (start + i < mq.size()) got = mq[start + i];
      end
      checks++;
      assert (got === exp) else begin
        errors++;
        $error("FAIL %s beat %0d: observed=%h expected=%h", tag, i, got, exp);
      end
    end
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [7:0] u);
    in_tvalid = 1'b1; in_tdata = d; in_tkeep = k; in_tlast = l; in_tuser = u;
    @(posedge clk); #1;
    in_tvalid = 1'b0; in_tlast = 1'b0;
  endtask

  task automatic send_pkt(input int n, input logic [63:0] base, input logic [7:0] lastkeep, input logic [7:0] u);
    for (int i = 0; i < n; i++) begin
      send_beat(base + 64'(i), ((i == n - 1) ? lastkeep : 8'hFF), (i == n - 1), u);
    end
  endtask

  task automatic do_reset(input string tag);
    sresetn = 1'b0; in_tvalid = 1'b0; in_tlast = 1'b0; out_tready = 1'b0; stat_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_in_tready"}, 64'(m_in_tready), 64'd0);
    chk({tag, "_out_tvalid"}, 64'(m_out_tvalid), 64'd0);
    chk({tag, "_drop_pulse"}, 64'(m_drop_pulse), 64'd0);
    chk({tag, "_fill"}, 64'(m_fill_words), 64'd0);
    chk({tag, "_pkt_count"}, 64'(m_pkt_count), 64'd0);
    chk({tag, "_drop_full"}, 64'(m_drop_full_cnt), 64'd0);
    chk({tag, "_drop_mtu"}, 64'(m_drop_mtu_cnt), 64'd0);
    chk({tag, "_lim_out_tvalid"}, 64'(l_out_tvalid), 64'd0);
    sresetn = 1'b1;
    #1;
    chk({tag, "_tready_before_edge"}, 64'(m_in_tready), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_tready_after_edge"}, 64'(m_in_tready), 64'd1);
  endtask

  initial begin
    int m0, l0, p0;

    do_reset("rst0");

    // Basic 3-beat packet, last tkeep 0x0F, tuser 0x5.
    out_tready = 1'b1;
    m0 = mq.size();
    send_pkt(3, 64'h1111_0000, 8'h0F, 8'h05);
    chk("basic_pkt_count_commit", 64'(m_pkt_count), 64'd1);
    chk("basic_fill_commit", 64'(m_fill_words), 64'd3);
    chk("basic_no_early_valid", 64'(m_out_tvalid), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("basic_valid_latency", 64'(m_out_tvalid), 64'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("basic_beats_out", 64'(mq.size() - m0), 64'd3);
    chk_pkt("basic", 1'b0, m0, 3, 64'h1111_0000, 8'h0F, 8'h05);
    chk("basic_pkt_count_drain", 64'(m_pkt_count), 64'd0);
    chk("basic_fill_drain", 64'(m_fill_words), 64'd0);

    // Overflow: two 10-beat packets into 16 words with the output stalled.
    out_tready = 1'b0;
    m0 = mq.size();
    p0 = m_pulses;
    send_pkt(10, 64'h100, 8'hFF, 8'h01);
    send_pkt(10, 64'h200, 8'hFF, 8'h02);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_drop_full", 64'(m_drop_full_cnt), 64'd1);
    chk("ovf_drop_mtu", 64'(m_drop_mtu_cnt), 64'd0);
    chk("ovf_pulses", 64'(m_pulses - p0), 64'd1);
    chk("ovf_fill", 64'(m_fill_words), 64'd10);
    chk("ovf_pkt_count", 64'(m_pkt_count), 64'd1);
    chk("ovf_stall_valid", 64'(m_out_tvalid), 64'd1);
    chk("ovf_stall_data0", m_out_tdata, 64'h100);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_stall_data1", m_out_tdata, 64'h100);
    chk("ovf_stall_user", 64'(m_out_tuser), 64'h01);
    out_tready = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    chk("ovf_beats_out", 64'(mq.size() - m0), 64'd10);
    chk_pkt("ovf_pkt1", 1'b0, m0, 10, 64'h100, 8'hFF, 8'h01);

    // Commit and out_tlast handshake in the same cycle, then a 1-beat stream.
    out_tready = 1'b0;
    m0 = mq.size();
    send_beat(64'hA0, 8'hFF, 1'b1, 8'h0A);
    send_beat(64'hA1, 8'hFF, 1'b1, 8'h0A);
    repeat (3) @(posedge clk);
    #1;
    chk("conc_pkt_count_before", 64'(m_pkt_count), 64'd2);
    chk("conc_head_valid", 64'(m_out_tvalid), 64'd1);
    out_tready = 1'b1;
    send_beat(64'hA2, 8'hFF, 1'b1, 8'h0A);
    chk("conc_pkt_count_same", 64'(m_pkt_count), 64'd2);
    for (int i = 0; i < 6; i++) send_beat(64'h50 + 64'(i), 8'hFF, 1'b1, 8'h0B);
    repeat (10) @(posedge clk);
    #1;
    chk("conc_beats_out", 64'(mq.size() - m0), 64'd9);
    for (int i = 0; i < 3; i++) chk_pkt("conc_a", 1'b0, m0 + i, 1, 64'hA0 + 64'(i), 8'hFF, 8'h0A);
    for (int i = 0; i < 6; i++) chk_pkt("conc_s", 1'b0, m0 + 3 + i, 1, 64'h50 + 64'(i), 8'hFF, 8'h0B);
    for (int k = 4; k < 9; k++) begin
      if (m0 + k < mstamp.size()) chk("conc_rate", 64'(mstamp[m0 + k] - mstamp[m0 + k - 1]), 64'd1);
      else chk("conc_rate_missing", 64'(mstamp.size()), 64'(m0 + k + 1));
    end

    // MTU 64 on the limited queue: 72 B packet dropped, exact 64 B passes.
    do_reset("rst_mtu");
    out_tready = 1'b1;
    l0 = lq.size();
    send_pkt(9, 64'h300, 8'hFF, 8'h03);
    send_pkt(8, 64'h400, 8'hFF, 8'h04);
    repeat (20) @(posedge clk);
    #1;
    chk("mtu_drop_mtu", 64'(l_drop_mtu_cnt), 64'd1);
    chk("mtu_drop_full", 64'(l_drop_full_cnt), 64'd0);
    chk("mtu_main_no_drop", 64'(m_drop_mtu_cnt), 64'd0);
    chk("mtu_beats_out", 64'(lq.size() - l0), 64'd8);
    chk_pkt("mtu_64B", 1'b1, l0, 8, 64'h400, 8'hFF, 8'h04);

    // Packet limit: three 1-beat packets into a 2-packet queue, stalled.
    out_tready = 1'b0;
    p0 = l_pulses;
    for (int i = 0; i < 3; i++) send_beat(64'h600 + 64'(i), 8'h03, 1'b1, 8'h06);
    repeat (2) @(posedge clk);
    #1;
    chk("lim_pkt_count", 64'(l_pkt_count), 64'd2);
    chk("lim_drop_full", 64'(l_drop_full_cnt), 64'd1);
    chk("lim_pulses", 64'(l_pulses - p0), 64'd1);
    chk("lim_main_pkt_count", 64'(m_pkt_count), 64'd3);
    stat_clear = 1'b1;
    send_beat(64'h603, 8'h03, 1'b1, 8'h06);
    stat_clear = 1'b0;
    chk("lim_clear_vs_drop", 64'(l_drop_full_cnt), 64'd0);
    chk("lim_main_full_pkts", 64'(m_pkt_count), 64'd4);
    send_beat(64'h604, 8'h03, 1'b1, 8'h06);
    chk("lim_main_drop_at_max", 64'(m_drop_full_cnt), 64'd1);
    chk("lim_drop_after_clear", 64'(l_drop_full_cnt), 64'd1);

    // Reset in the middle of a packet, then a clean packet.
    send_beat(64'h800, 8'hFF, 1'b0, 8'h08);
    send_beat(64'h801, 8'hFF, 1'b0, 8'h08);
    do_reset("rst_mid");
    out_tready = 1'b1;
    m0 = mq.size();
    l0 = lq.size();
    send_pkt(3, 64'h700, 8'h01, 8'h07);
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_beats", 64'(mq.size() - m0), 64'd3);
    chk_pkt("post_rst_main", 1'b0, m0, 3, 64'h700, 8'h01, 8'h07);
    chk_pkt("post_rst_lim", 1'b1, l0, 3, 64'h700, 8'h01, 8'h07);
    chk("post_rst_pkt_count", 64'(m_pkt_count), 64'd0);
    chk("post_rst_drop_full", 64'(m_drop_full_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
